// File: rtl/slot_sched_if.sv
// Slot scheduler bus: round control, MAC handshake and modulator drive.
// Master drives start/payload/grant; the scheduler is the slave.
interface slot_sched_if #(
  parameter int PKT_BITS  = 32,
  parameter int NUM_SLOTS = 16
);
  localparam int TW = $clog2(NUM_SLOTS + 1);

  logic                start;
  logic [PKT_BITS-1:0] payload;
  logic                mac_grant;
  logic                mac_enable;
  logic                mod_en;
  logic                mod_out;
  logic                busy;
  logic                done;
  logic [TW-1:0]       tx_count;

  modport master (
    output start, payload, mac_grant,
    input  mac_enable, mod_en, mod_out,
    input  busy, done, tx_count
  );

  modport slave (
    input  start, payload, mac_grant,
    output mac_enable, mod_en, mod_out,
    output busy, done, tx_count
  );
endinterface

// File: rtl/slot_sched.sv
// Round/slot scheduler: samples MAC grant at each slot head and
// serializes the latched payload MSB first in granted slots.
module slot_sched #(
  parameter int SLOT_CYCLES = 1024,
  parameter int BIT_CYCLES  = 16,
  parameter int PKT_BITS    = 32,
  parameter int NUM_SLOTS   = 16
) (
  input logic        clk,
  input logic        rst,
  slot_sched_if.slave bus
);

  localparam int CW  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIW = (PKT_BITS > 1) ? $clog2(PKT_BITS) : 1;
  localparam int TW  = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_TX,
    S_TAIL
  } state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [CW-1:0]       r_cyc;
  logic [SW-1:0]       r_slot;
  logic [BCW-1:0]      r_bc;
  logic [BIW-1:0]      r_bi;
  logic [PKT_BITS-1:0] r_pay;
  logic [TW-1:0]       r_txc;

  logic w_cyc_end;
  logic w_last;
  logic w_bit_end;

  assign w_cyc_end = (r_cyc == CW'(SLOT_CYCLES - 1));
  assign w_last    = (r_slot == SW'(NUM_SLOTS - 1));
  assign w_bit_end = (r_bc == BCW'(BIT_CYCLES - 1));

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_nxt = S_HEAD;
      S_HEAD: w_nxt = bus.mac_grant ? S_TX : S_TAIL;
      S_TX: begin
        if (w_bit_end && r_bi == '0) w_nxt = S_TAIL;
      end
      S_TAIL: begin
        if (w_cyc_end) w_nxt = w_last ? S_IDLE : S_HEAD;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_slot  <= '0;
      r_bc    <= '0;
      r_bi    <= '0;
      r_pay   <= '0;
      r_txc   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_pay  <= bus.payload;
          r_txc  <= '0;
          r_cyc  <= '0;
          r_slot <= '0;
        end
      end else begin
        r_cyc <= w_cyc_end ? '0 : r_cyc + 1'b1;
      end
      // Grant only counts when sampled at the slot head
      if (r_state == S_HEAD && bus.mac_grant) begin
        if (r_txc != TW'(NUM_SLOTS)) r_txc <= r_txc + 1'b1;
        r_bi <= BIW'(PKT_BITS - 1);
        r_bc <= '0;
      end
      if (r_state == S_TX) begin
        if (w_bit_end) begin
          r_bc <= '0;
          if (r_bi != '0) r_bi <= r_bi - 1'b1;
        end else begin
          r_bc <= r_bc + 1'b1;
        end
      end
      if (r_state == S_TAIL && w_cyc_end && !w_last) begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.mac_enable = (r_state != S_IDLE);
  assign bus.mod_en     = (r_state == S_TX);
  assign bus.mod_out    = (r_state == S_TX) ? r_pay[r_bi] : 1'b0;
  assign bus.done       = (r_state == S_TAIL) && w_cyc_end && w_last;
  assign bus.tx_count   = r_txc;

endmodule

// File: tb/tb_slot_sched.sv
// Directed bench for slot_sched: reset, grant patterns, abort,
// ignored starts, back-to-back rounds.
module tb_slot_sched;

  localparam int SC  = 64;
  localparam int BC  = 2;
  localparam int PB  = 8;
  localparam int NS  = 4;
  localparam int LEN = SC * NS;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  slot_sched_if #(.PKT_BITS(PB), .NUM_SLOTS(NS)) bus ();

  slot_sched #(
    .SLOT_CYCLES(SC),
    .BIT_CYCLES (BC),
    .PKT_BITS   (PB),
    .NUM_SLOTS  (NS)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic round(string tag, logic [3:0] gmask,
                       logic [7:0] pay, logic noise,
                       int ign_at, logic [7:0] ign_pay,
                       int exp_txc);
    int en_err = 0, out_err = 0, me_err = 0;
    int dcnt = 0, dpos = 0, blen = 0;
    int slot, cyc;
    logic e_en, e_out;
    bus.payload = pay;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.payload = 8'h00;
    chk({tag, "_busy1"}, bus.busy, 1);
    chk({tag, "_men1"}, bus.mac_enable, 1);
    for (int k = 1; k <= LEN; k++) begin
      slot = (k - 1) / SC;
      cyc  = (k - 1) % SC;
      bus.mac_grant = (cyc == 0) ? gmask[slot] : noise;
      if (k == ign_at) begin
        bus.start   = 1'b1;
        bus.payload = ign_pay;
      end else begin
        bus.start   = 1'b0;
      end
      e_en  = gmask[slot] && cyc >= 1 && cyc <= PB * BC;
      e_out = e_en ? pay[PB - 1 - (cyc - 1) / BC] : 1'b0;
      if (bus.mod_en !== e_en) en_err++;
      if (bus.mod_out !== e_out) out_err++;
      if (bus.mac_enable !== 1'b1) me_err++;
      if (bus.busy === 1'b1) blen++;
      if (bus.done === 1'b1) begin
        dcnt++;
        dpos = k;
      end
      tick();
    end
    bus.start     = 1'b0;
    bus.mac_grant = 1'b0;
    chk({tag, "_en_err"}, en_err, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_men_err"}, me_err, 0);
    chk({tag, "_blen"}, blen, LEN);
    chk({tag, "_dcnt"}, dcnt, 1);
    chk({tag, "_dpos"}, dpos, LEN);
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_men_end"}, bus.mac_enable, 0);
    chk({tag, "_done_end"}, bus.done, 0);
    chk({tag, "_txc"}, bus.tx_count, exp_txc);
  endtask

  initial begin
    int dc, bc;
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.payload   = 8'hFF;
    bus.mac_grant = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_men", bus.mac_enable, 0);
    chk("rst_mod_en", bus.mod_en, 0);
    chk("rst_mod_out", bus.mod_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_txc", bus.tx_count, 0);
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.mac_grant = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    round("all", 4'hF, 8'hA5, 1'b1, 0, 8'h00, 4);
    tick();
    chk("hold_txc", bus.tx_count, 4);
    round("sparse", 4'b0100, 8'h5A, 1'b1, LEN, 8'hFF, 1);
    round("none", 4'b0000, 8'hFF, 1'b1, 0, 8'h00, 0);
    round("ign", 4'b0011, 8'h96, 1'b0, SC + 1, 8'h69, 2);

    bus.payload   = 8'hF0;
    bus.start     = 1'b1;
    bus.mac_grant = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < SC + 6; k++) tick();
    chk("ab_pre_en", bus.mod_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mac_grant = 1'b0;
    chk("ab_mod_en", bus.mod_en, 0);
    chk("ab_men", bus.mac_enable, 0);
    chk("ab_busy", bus.busy, 0);
    chk("ab_txc", bus.tx_count, 0);
    dc = 0;
    bc = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) dc++;
      if (bus.busy === 1'b1) bc++;
      tick();
    end
    chk("ab_no_done", dc, 0);
    chk("ab_stay_idle", bc, 0);

    round("post", 4'hF, 8'hC3, 1'b0, 0, 8'h00, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/slot_sched.md
Name: slot_sched

Overview:
- Round/slot scheduler that sits directly downstream of the random-access MAC decision stage.
- Drives the MAC stage's enable input and samples its grant output once per slot.
- In each granted slot it serializes the tag payload onto the backscatter modulator drive.
- Runs a round of NUM_SLOTS fixed-length slots, then reports completion.

Parameters:
- SLOT_CYCLES, 1024, clk cycles per slot; must be ≥ PKT_BITS*BIT_CYCLES+2.
- BIT_CYCLES, 16, clk cycles each payload bit is held on mod_out.
- PKT_BITS, 32, payload length in bits.
- NUM_SLOTS, 16, slots per round.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a round when idle.
- payload  in  PKT_BITS  packet to send; latched on accepted start.
- mac_grant  in  1  grant from MAC stage; 1 = transmit in this slot.
- mac_enable  out  1  held 1 for the whole round; 0 in idle, which reseeds the MAC stage.
- mod_en  out  1  1 while a payload bit is being driven.
- mod_out  out  1  current payload bit; 0 when mod_en=0.
- busy  out  1  1 from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse in the last cycle of a round.
- tx_count  out  $clog2(NUM_SLOTS+1)  granted slots in the current or last round.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. mac_enable, mod_en, mod_out, busy, done = 0. tx_count=0. All counters 0. Takes priority over every other input, including mid-round; no done is generated on abort.
- States: IDLE, SLOT_HEAD, TX, SLOT_TAIL.
- Counters: cyc counts 0..SLOT_CYCLES-1 within a slot. slot counts 0..NUM_SLOTS-1. Bit index bi and per-bit counter bc are used during TX.
- IDLE:
  - start=1 → latch payload, clear tx_count, cyc=0, slot=0; next state SLOT_HEAD.
  - busy and mac_enable go 1 in the following cycle.
  - start while not IDLE is ignored.
- SLOT_HEAD (cyc==0 of every slot): sample mac_grant in this cycle only.
  - mac_grant=1 → tx_count+1 (saturates at NUM_SLOTS), bi=PKT_BITS-1, bc=0; next state TX.
  - mac_grant=0 → next state SLOT_TAIL.
- TX:
  - mod_en=1 and mod_out=payload[bi], MSB first.
  - Each bit is held exactly BIT_CYCLES cycles, so TX occupies cyc 1..PKT_BITS*BIT_CYCLES.
  - After bit 0 completes, mod_en=0 and mod_out=0 in the next cycle; next state SLOT_TAIL.
- SLOT_TAIL: idle until cyc==SLOT_CYCLES-1.
  - If slot<NUM_SLOTS-1: slot+1, cyc=0; next state SLOT_HEAD.
  - Otherwise: done=1 this cycle; next state IDLE, where busy=0 and mac_enable=0.
- Round length: exactly NUM_SLOTS*SLOT_CYCLES cycles of busy.
- cyc increments every cycle in all non-IDLE states.
- mac_grant is ignored outside SLOT_HEAD.
- Width rules:
  - cyc width: $clog2(SLOT_CYCLES).
  - slot width: $clog2(NUM_SLOTS), minimum 1.
  - bc width: $clog2(BIT_CYCLES), minimum 1.
  - bi width: $clog2(PKT_BITS), minimum 1.
  - BIT_CYCLES=1 is legal: one bit per cycle.
- start pulse coinciding with done: ignored, because state is not IDLE. A start one cycle after done is accepted.
- tx_count holds its value after done until the next accepted start or rst.

Test Plan:
- Reset: assert rst 3 cycles with start=1 → all outputs 0. Deassert rst, pulse start → busy=1 and mac_enable=1 one cycle later.
- All-grant round: SLOT_CYCLES=64, BIT_CYCLES=2, PKT_BITS=8, NUM_SLOTS=4, payload=8'hA5, mac_grant=1 constant. Required response:
  - Each slot: mod_en high for cyc 1..16.
  - mod_out pattern 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1.
  - done at cycle 256 after start; tx_count=4.
- Sparse grant: mac_grant=1 only during slot 2 head → single burst starting 2*64+1 cycles after round start, tx_count=1, busy 256 cycles.
- No grant: mac_grant=0 → mod_en never 1, tx_count=0, done still pulses once after 256 cycles.
- Abort: rst mid-TX in slot 1 → next cycle mod_en=0, mac_enable=0, busy=0, no done. A new start runs a full round normally.
- Start ignored: pulse start at slot 1 with a new payload → round length unchanged and the original payload is still sent. A start on the done cycle is ignored; a start on done+1 is accepted.
